spi_flash_seq: RTL and testbench

SPI_FLASH_SEQ -- requirements
Module: spi_flash_seq

---
 rtl/spi_flash_pkg.sv | 52 +++++
 rtl/spi_cmd_issue.sv | 59 +++++
 rtl/spi_flash_seq.sv | 194 +++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared opcodes, encodings, state types and frame builders for the SPI flash sequencer
// Purpose: single home for flash opcodes, op_code encodings and FSM state encodings.
// Ports: none (package).
package spi_flash_pkg;

    localparam int CMD_W   = 2080;
    localparam int WDATA_W = 2048;

    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_PP   = 8'h02;
    localparam logic [7:0] OPC_SE   = 8'hD8;
    localparam logic [7:0] OPC_RDSR = 8'h05;

    typedef enum logic [1:0] {
        OP_ERASE   = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_RDSR    = 2'd2,
        OP_RSVD    = 2'd3
    } op_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_OP,
        ST_POLL,
        ST_FINISH
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ISSUE,
        PH_WAIT_HI,
        PH_WAIT_LO
    } cmd_phase_e;

    // Page program frame: {0x02, addr, wdata} shifted so that only the first
    // wlen data bytes remain and the opcode lands at [(wlen+4)*8-1 -: 8].
    function automatic logic [CMD_W-1:0] prog_frame(
        input logic [23:0]        addr,
        input logic [WDATA_W-1:0] wdata,
        input logic [8:0]         wlen
    );
        logic [11:0] shamt;
        shamt = {9'd256 - wlen, 3'b000};
        return {OPC_PP, addr, wdata} >> shamt;
    endfunction

    function automatic logic [CMD_W-1:0] erase_frame(input logic [23:0] addr);
        return CMD_W'({OPC_SE, addr});
    endfunction

endpackage

// File: rtl/spi_cmd_issue.sv
// rtl/spi_cmd_issue.sv - ISSUE/WAIT_HI/WAIT_LO handshake with the SPI command engine
// Purpose: launches one engine command per request and reports its completion.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   cmd_req       - level: a command is wanted (sequencer sits in a command state)
//   cmd_busy      - engine busy flag
//   cmd_trigger   - one-cycle launch pulse, only while cmd_busy is low
//   cmd_done      - one-cycle pulse when the engine drops busy after the launch
module spi_cmd_issue
    import spi_flash_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic cmd_req,
    input  logic cmd_busy,
    output logic cmd_trigger,
    output logic cmd_done
);

    cmd_phase_e phase_q, phase_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Completion always returns to PH_IDLE, giving the sequencer one cycle
    // with its new command registers before the next launch.
    always_comb begin
        phase_d     = phase_q;
        cmd_trigger = 1'b0;
        cmd_done    = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                if (cmd_req) phase_d = PH_ISSUE;
            end
            PH_ISSUE: begin
                if (!cmd_busy) begin
                    cmd_trigger = 1'b1;
                    phase_d     = PH_WAIT_HI;
                end
            end
            PH_WAIT_HI: begin
                if (cmd_busy) phase_d = PH_WAIT_LO;
            end
            PH_WAIT_LO: begin
                if (!cmd_busy) begin
                    cmd_done = 1'b1;
                    phase_d  = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

endmodule

// File: rtl/spi_flash_seq.sv
// rtl/spi_flash_seq.sv - SPI NOR flash operation sequencer (erase / program / read status)
// Purpose: turns one accepted operation into WREN / OP / POLL engine commands.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   op_valid/op_ready             - operation handshake (ready only in IDLE)
//   op_code/op_addr/op_wdata/op_wlen - operation fields, captured at acceptance
//   op_done/op_error/op_status    - completion pulse, error qualifier, last status byte
//   cmd_trigger/cmd_busy          - engine launch pulse and busy flag
//   cmd_count/cmd_rx/cmd_data     - engine command: byte count, receive flag, right-aligned bytes
//   cmd_rdata                     - byte returned by a receive command
//   cmd_quad                      - quad mode select, tied low
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op_code,
    input  logic [23:0]        op_addr,
    input  logic [WDATA_W-1:0] op_wdata,
    input  logic [8:0]         op_wlen,
    output logic               op_done,
    output logic               op_error,
    output logic [7:0]         op_status,
    output logic               cmd_trigger,
    input  logic               cmd_busy,
    output logic [8:0]         cmd_count,
    output logic               cmd_rx,
    output logic [CMD_W-1:0]   cmd_data,
    input  logic [7:0]         cmd_rdata,
    output logic               cmd_quad
);

    seq_state_e         state_q, state_d;
    op_code_e           code_q, code_d;
    logic [23:0]        addr_q, addr_d;
    logic [8:0]         wlen_q, wlen_d;
    logic [WDATA_W-1:0] wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [7:0]         status_q, status_d;
    logic [15:0]        poll_cnt_q, poll_cnt_d;
    logic [8:0]         cnt_q, cnt_d;
    logic               rx_q, rx_d;
    logic [CMD_W-1:0]   data_q, data_d;
    logic               init_q, init_d;

    logic               cmd_req;
    logic               cmd_done;
    logic               accept;
    logic               bad_op;
    logic [16:0]        polls_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            code_q     <= OP_ERASE;
            addr_q     <= '0;
            wlen_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            status_q   <= '0;
            poll_cnt_q <= '0;
            cnt_q      <= '0;
            rx_q       <= 1'b0;
            data_q     <= '0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            addr_q     <= addr_d;
            wlen_q     <= wlen_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            status_q   <= status_d;
            poll_cnt_q <= poll_cnt_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            data_q     <= data_d;
            init_q     <= init_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        addr_d     = addr_q;
        wlen_d     = wlen_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        status_d   = status_q;
        poll_cnt_d = poll_cnt_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        data_d     = data_q;
        // After reset the engine may still be finishing an aborted command;
        // hold off accepting work until it has gone idle once.
        init_d     = init_q | ~cmd_busy;

        accept     = (state_q == ST_IDLE) && init_q && op_valid;
        bad_op     = (op_code == 2'd3) ||
                     ((op_code == 2'd1) && ((op_wlen == 9'd0) || (op_wlen > 9'd256)));
        polls_next = {1'b0, poll_cnt_q} + 17'd1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d  = op_code_e'(op_code);
                    addr_d  = op_addr;
                    wlen_d  = op_wlen;
                    wdata_d = op_wdata;
                    err_d   = bad_op;
                    if (bad_op) begin
                        state_d = ST_FINISH;
                    end else if (op_code == 2'd2) begin
                        state_d    = ST_POLL;
                        poll_cnt_d = '0;
                        cnt_d      = 9'd1;
                        rx_d       = 1'b1;
                        data_d     = CMD_W'(OPC_RDSR);
                    end else begin
                        state_d = ST_WREN;
                        cnt_d   = 9'd1;
                        rx_d    = 1'b0;
                        data_d  = CMD_W'(OPC_WREN);
                    end
                end
            end
            ST_WREN: begin
                if (cmd_done) begin
                    state_d = ST_OP;
                    rx_d    = 1'b0;
                    if (code_q == OP_ERASE) begin
                        cnt_d  = 9'd4;
                        data_d = erase_frame(addr_q);
                    end else begin
                        cnt_d  = wlen_q + 9'd4;
                        data_d = prog_frame(addr_q, wdata_q, wlen_q);
                    end
                end
            end
            ST_OP: begin
                if (cmd_done) begin
                    state_d    = ST_POLL;
                    poll_cnt_d = '0;
                    cnt_d      = 9'd1;
                    rx_d       = 1'b1;
                    data_d     = CMD_W'(OPC_RDSR);
                end
            end
            ST_POLL: begin
                // Staying in ST_POLL keeps cmd_req high, so the issue block
                // relaunches the same 0x05 command.
                if (cmd_done) begin
                    status_d   = cmd_rdata;
                    poll_cnt_d = polls_next[15:0];
                    if ((code_q == OP_RDSR) || !cmd_rdata[0]) begin
                        state_d = ST_FINISH;
                    end else if (polls_next >= {1'b0, POLL_LIMIT}) begin
                        state_d = ST_FINISH;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_req = (state_q == ST_WREN) || (state_q == ST_OP) || (state_q == ST_POLL);

    spi_cmd_issue u_issue (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_req     (cmd_req),
        .cmd_busy    (cmd_busy),
        .cmd_trigger (cmd_trigger),
        .cmd_done    (cmd_done)
    );

    assign op_ready  = (state_q == ST_IDLE) && init_q;
    assign op_done   = (state_q == ST_FINISH);
    assign op_error  = (state_q == ST_FINISH) && err_q;
    assign op_status = status_q;
    assign cmd_count = cnt_q;
    assign cmd_rx    = rx_q;
    assign cmd_data  = data_q;
    assign cmd_quad  = 1'b0;

endmodule

// File: tb/tb_spi_flash_seq.sv
// tb/tb_spi_flash_seq.sv - randomized self-checking bench for spi_flash_seq
module tb_spi_flash_seq;

    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_code;
    logic [23:0]   op_addr;
    logic [2047:0] op_wdata;
    logic [8:0]    op_wlen;
    logic          op_done;
    logic          op_error;
    logic [7:0]    op_status;
    logic          cmd_trigger;
    logic          cmd_busy;
    logic [8:0]    cmd_count;
    logic          cmd_rx;
    logic [2079:0] cmd_data;
    logic [7:0]    cmd_rdata;
    logic          cmd_quad;

    always #5 clk = ~clk;

    spi_flash_seq #(.POLL_LIMIT(16'(LIMIT))) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_wlen(op_wlen),
        .op_done(op_done), .op_error(op_error), .op_status(op_status),
        .cmd_trigger(cmd_trigger), .cmd_busy(cmd_busy), .cmd_count(cmd_count),
        .cmd_rx(cmd_rx), .cmd_data(cmd_data), .cmd_rdata(cmd_rdata), .cmd_quad(cmd_quad)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Command engine model: records every trigger, raises busy after 0..2
    // cycles, holds it a random time, returns status bytes from a script.
    logic [8:0]    rec_cnt[$];
    logic          rec_rx[$];
    logic [2079:0] rec_data[$];
    logic [7:0]    st_script[$];
    logic [7:0]    st_default = 8'h00;
    int            busy_extra = 0;
    int            stab_viol = 0;

    initial begin : engine
        int            ph;
        int            wait_n;
        logic [8:0]    s_cnt;
        logic          s_rx;
        logic [2079:0] s_data;
        logic          abort;
        ph = 0; wait_n = 0; abort = 1'b0; s_cnt = '0; s_rx = 1'b0; s_data = '0;
        cmd_busy = 1'b0; cmd_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b0) abort = 1'b1;
            if (ph != 0 && cmd_trigger === 1'b1) stab_viol++;
            if (ph != 0 && !abort && (cmd_count !== s_cnt || cmd_rx !== s_rx || cmd_data !== s_data))
                stab_viol++;
            case (ph)
                0: if (cmd_trigger === 1'b1) begin
                    rec_cnt.push_back(cmd_count); rec_rx.push_back(cmd_rx); rec_data.push_back(cmd_data);
                    s_cnt = cmd_count; s_rx = cmd_rx; s_data = cmd_data; abort = 1'b0;
                    ph = 1; wait_n = $urandom_range(0, 2);
                end
                1: if (wait_n == 0) begin
                    cmd_busy = 1'b1; ph = 2; wait_n = $urandom_range(1, 4) + busy_extra;
                end else wait_n--;
                default: if (wait_n == 0) begin
                    cmd_busy = 1'b0;
                    if (s_rx) cmd_rdata = (st_script.size() > 0) ? st_script.pop_front() : st_default;
                    else      cmd_rdata = 8'($urandom);
                    ph = 0;
                end else wait_n--;
            endcase
        end
    end

    // Reference model: command list and outcome from the operation rules.
    logic [8:0]    exp_cnt[$];
    logic          exp_rx[$];
    logic [2079:0] exp_data[$];
    logic          exp_err;
    logic [7:0]    exp_status = 8'h00;

    task automatic model_op(input logic [1:0] code, input logic [23:0] addr, input logic [8:0] wlen,
                            input logic [2047:0] wdata, input logic [7:0] script[$], input logic [7:0] dflt);
        logic [2079:0] d;
        logic [7:0]    s;
        int            n;
        exp_cnt.delete(); exp_rx.delete(); exp_data.delete();
        if (code == 2'd3 || (code == 2'd1 && (wlen == 0 || wlen > 256))) begin
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        if (code != 2'd2) begin
            exp_cnt.push_back(9'd1); exp_rx.push_back(1'b0); exp_data.push_back(2080'h06);
        end
        if (code == 2'd0) begin
            exp_cnt.push_back(9'd4); exp_rx.push_back(1'b0); exp_data.push_back({2048'h0, 8'hD8, addr});
        end
        if (code == 2'd1) begin
            d = 2080'h02;
            d = (d << 24) | 2080'(addr);
            for (int i = 0; i < int'(wlen); i++) d = (d << 8) | 2080'(wdata[2047-8*i -: 8]);
            exp_cnt.push_back(9'(wlen + 9'd4)); exp_rx.push_back(1'b0); exp_data.push_back(d);
        end
        n = 0;
        forever begin
            n++;
            s = (script.size() > 0) ? script.pop_front() : dflt;
            exp_cnt.push_back(9'd1); exp_rx.push_back(1'b1); exp_data.push_back(2080'h05);
            exp_status = s;
            if (code == 2'd2 || !s[0]) break;
            if (n >= LIMIT) begin exp_err = 1'b1; break; end
        end
    endtask

    function automatic logic [2047:0] rand_wdata();
        logic [2047:0] w;
        for (int i = 0; i < 64; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Driver: presents one op, scrambles the inputs after acceptance while
    // keeping op_valid high, and waits (bounded) for op_done.
    logic       got_done;
    logic       got_err;
    logic [7:0] got_status;
    int         got_cycles;

    task automatic drive_op(input logic [1:0] code, input logic [23:0] addr, input logic [8:0] wlen,
                            input logic [2047:0] wdata);
        int k;
        got_done = 1'b0; got_err = 1'b0; got_status = 8'h00; got_cycles = 0; k = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        rec_cnt.delete(); rec_rx.delete(); rec_data.delete();
        op_valid = 1'b1; op_code = code; op_addr = addr; op_wlen = wlen; op_wdata = wdata;
        @(posedge clk); #1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (op_done === 1'b1) begin
                got_done = 1'b1; got_err = op_error; got_status = op_status; got_cycles = c;
                break;
            end
            op_code = 2'($urandom); op_addr = 24'($urandom); op_wlen = 9'($urandom); op_wdata = rand_wdata();
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; op_valid = 1'b0; op_code = 2'd0; op_addr = '0; op_wlen = '0; op_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({op_ready, cmd_trigger, op_done, op_error, op_status, cmd_count, cmd_rx, cmd_quad} !== 22'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy %b trg %b done %b err %b st %h cnt %0d rx %b quad %b, expected all 0",
                     op_ready, cmd_trigger, op_done, op_error, op_status, cmd_count, cmd_rx, cmd_quad);
        end
        n_checks++;
        if (cmd_data !== 2080'h0) begin
            n_errors++; $display("FAIL reset_cmd_data: got low %h, expected 0", cmd_data[127:0]);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (op_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_release_ready: got %b, expected 1", op_ready);
        end
    endtask

    task automatic test_erase();
        logic [7:0] scr[$];
        scr = '{8'h03, 8'h81, 8'h40};
        st_script = scr; st_default = 8'hFF;
        model_op(2'd0, 24'h012345, 9'd0, '0, scr, 8'hFF);
        drive_op(2'd0, 24'h012345, 9'd0, rand_wdata());
        n_checks++;
        if (got_done !== 1'b1 || got_err !== 1'b0) begin
            n_errors++; $display("FAIL erase_done: got done %b err %b, expected done 1 err 0", got_done, got_err);
        end
        n_checks++;
        if (rec_cnt.size() != 5) begin
            n_errors++; $display("FAIL erase_trigger_count: got %0d, expected 5", rec_cnt.size());
        end
        n_checks++;
        if (rec_data[1][31:0] !== 32'hD8012345 || rec_cnt[1] !== 9'd4) begin
            n_errors++; $display("FAIL erase_op_frame: got %h cnt %0d, expected d8012345 cnt 4", rec_data[1][31:0], rec_cnt[1]);
        end
        for (int i = 0; i < exp_cnt.size(); i++) begin
            n_checks++;
            if (rec_cnt[i] !== exp_cnt[i] || rec_rx[i] !== exp_rx[i] || rec_data[i] !== exp_data[i]) begin
                n_errors++;
                $display("FAIL erase_cmd%0d: got cnt %0d rx %b data %h, expected cnt %0d rx %b data %h",
                         i, rec_cnt[i], rec_rx[i], rec_data[i][63:0], exp_cnt[i], exp_rx[i], exp_data[i][63:0]);
            end
        end
        n_checks++;
        if (got_status !== exp_status) begin
            n_errors++; $display("FAIL erase_status: got %h, expected %h", got_status, exp_status);
        end
    endtask

    task automatic test_program_full();
        logic [7:0]    scr[$];
        logic [2047:0] wd;
        scr = '{8'h00};
        wd = rand_wdata();
        st_script = scr; st_default = 8'hFF;
        model_op(2'd1, 24'h000100, 9'd256, wd, scr, 8'hFF);
        drive_op(2'd1, 24'h000100, 9'd256, wd);
        n_checks++;
        if (got_done !== 1'b1 || got_err !== 1'b0 || rec_cnt.size() != 3) begin
            n_errors++; $display("FAIL prog256_done: got done %b err %b triggers %0d, expected 1 0 3",
                                 got_done, got_err, rec_cnt.size());
        end
        n_checks++;
        if (rec_cnt[1] !== 9'd260 || rec_data[1][2079:2072] !== 8'h02 || rec_data[1][2071:2048] !== 24'h000100) begin
            n_errors++; $display("FAIL prog256_header: got cnt %0d op %h addr %h, expected 260 02 000100",
                                 rec_cnt[1], rec_data[1][2079:2072], rec_data[1][2071:2048]);
        end
        n_checks++;
        if (rec_data[1] !== exp_data[1]) begin
            n_errors++; $display("FAIL prog256_payload: got low %h, expected low %h", rec_data[1][127:0], exp_data[1][127:0]);
        end
    endtask

    task automatic test_read_status();
        logic [7:0] scr[$];
        scr = '{8'hA5};
        st_script = scr; st_default = 8'hFF;
        model_op(2'd2, 24'h0, 9'd0, '0, scr, 8'hFF);
        drive_op(2'd2, 24'($urandom), 9'($urandom), rand_wdata());
        n_checks++;
        if (rec_cnt.size() != 1 || rec_rx[0] !== 1'b1 || rec_data[0] !== 2080'h05 || rec_cnt[0] !== 9'd1) begin
            n_errors++; $display("FAIL rdsr_cmd: got triggers %0d rx %b data %h cnt %0d, expected 1 1 05 1",
                                 rec_cnt.size(), rec_rx[0], rec_data[0][7:0], rec_cnt[0]);
        end
        n_checks++;
        if (got_done !== 1'b1 || got_err !== 1'b0 || got_status !== 8'hA5) begin
            n_errors++; $display("FAIL rdsr_result: got done %b err %b status %h, expected 1 0 a5",
                                 got_done, got_err, got_status);
        end
    endtask

    task automatic test_poll_timeout();
        logic [7:0] scr[$];
        int         polls;
        scr.delete();
        st_script = scr; st_default = 8'hFF;
        model_op(2'd0, 24'hABCDEF, 9'd0, '0, scr, 8'hFF);
        drive_op(2'd0, 24'hABCDEF, 9'd0, '0);
        polls = 0;
        foreach (rec_rx[i]) if (rec_rx[i] === 1'b1) polls++;
        n_checks++;
        if (polls != LIMIT) begin
            n_errors++; $display("FAIL timeout_polls: got %0d, expected %0d", polls, LIMIT);
        end
        n_checks++;
        if (got_done !== 1'b1 || got_err !== exp_err || exp_err !== 1'b1) begin
            n_errors++; $display("FAIL timeout_error: got done %b err %b, expected done 1 err 1", got_done, got_err);
        end
    endtask

    task automatic test_bad_ops();
        logic [1:0] codes[3];
        logic [8:0] lens[3];
        codes = '{2'd3, 2'd1, 2'd1};
        lens  = '{9'd5, 9'd0, 9'd300};
        for (int t = 0; t < 3; t++) begin
            drive_op(codes[t], 24'($urandom), lens[t], rand_wdata());
            n_checks++;
            if (rec_cnt.size() != 0 || got_done !== 1'b1 || got_err !== 1'b1 || got_cycles > 2) begin
                n_errors++; $display("FAIL bad_op%0d: got triggers %0d done %b err %b cycles %0d, expected 0 1 1 <=2",
                                     t, rec_cnt.size(), got_done, got_err, got_cycles);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int ntrig;
        logic busy_after;
        st_script.delete(); st_default = 8'h00; busy_extra = 8;
        k = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        rec_cnt.delete(); rec_rx.delete(); rec_data.delete();
        op_valid = 1'b1; op_code = 2'd1; op_addr = 24'($urandom); op_wlen = 9'($urandom_range(1, 256));
        op_wdata = rand_wdata();
        @(posedge clk); #1;
        op_valid = 1'b0;
        k = 0;
        while (!(rec_cnt.size() >= 2 && cmd_busy === 1'b1) && k < 300) begin @(negedge clk); k++; end
        n_checks++;
        if (k >= 300) begin
            n_errors++; $display("FAIL midreset_reach_op: got triggers %0d busy %b, expected 2 and busy", rec_cnt.size(), cmd_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({op_ready, cmd_trigger, op_done, op_error, op_status, cmd_count, cmd_rx} !== 21'd0 || cmd_data !== 2080'h0) begin
            n_errors++; $display("FAIL midreset_outputs: got rdy %b trg %b done %b err %b st %h cnt %0d rx %b, expected all 0",
                                 op_ready, cmd_trigger, op_done, op_error, op_status, cmd_count, cmd_rx);
        end
        exp_status = 8'h00;
        ntrig = rec_cnt.size();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        busy_after = cmd_busy;
        k = 0;
        @(posedge clk); #1;
        while (op_ready !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
        n_checks++;
        if (op_ready !== 1'b1 || cmd_busy !== 1'b0 || busy_after !== 1'b1) begin
            n_errors++; $display("FAIL midreset_ready: got ready %b busy %b busy_at_release %b, expected 1 0 1",
                                 op_ready, cmd_busy, busy_after);
        end
        n_checks++;
        if (rec_cnt.size() != ntrig || op_status !== 8'h00) begin
            n_errors++; $display("FAIL midreset_idle: got triggers %0d status %h, expected %0d 00",
                                 rec_cnt.size(), op_status, ntrig);
        end
        busy_extra = 0;
    endtask

    task automatic test_random();
        logic [7:0]    scr[$];
        logic [1:0]    code;
        logic [23:0]   addr;
        logic [8:0]    wlen;
        logic [2047:0] wd;
        int            nwip;
        for (int it = 0; it < 24; it++) begin
            code = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) code = 2'd3;
            else if (code == 2'd3) code = 2'd1;
            addr = 24'($urandom);
            case ($urandom_range(0, 5))
                0: wlen = 9'd1;
                1: wlen = 9'd256;
                2: wlen = ($urandom_range(0, 1) != 0) ? 9'd0 : 9'($urandom_range(257, 511));
                default: wlen = 9'($urandom_range(1, 256));
            endcase
            wd = rand_wdata();
            scr.delete();
            nwip = $urandom_range(0, 5);
            for (int j = 0; j < nwip; j++) scr.push_back(8'($urandom) | 8'h01);
            scr.push_back(8'($urandom) & 8'hFE);
            st_script = scr; st_default = 8'($urandom) | 8'h01;
            model_op(code, addr, wlen, wd, scr, st_default);
            drive_op(code, addr, wlen, wd);
            n_checks++;
            if (got_done !== 1'b1 || got_err !== exp_err || got_status !== exp_status || rec_cnt.size() != exp_cnt.size()) begin
                n_errors++; $display("FAIL rand%0d_outcome: got done %b err %b st %h trig %0d, expected 1 %b %h %0d",
                                     it, got_done, got_err, got_status, rec_cnt.size(), exp_err, exp_status, exp_cnt.size());
            end
            for (int i = 0; i < exp_cnt.size(); i++) begin
                n_checks++;
                if (rec_cnt[i] !== exp_cnt[i] || rec_rx[i] !== exp_rx[i] || rec_data[i] !== exp_data[i]) begin
                    n_errors++;
                    $display("FAIL rand%0d_cmd%0d: got cnt %0d rx %b data %h, expected cnt %0d rx %b data %h",
                             it, i, rec_cnt[i], rec_rx[i], rec_data[i][63:0], exp_cnt[i], exp_rx[i], exp_data[i][63:0]);
                end
            end
        end
    endtask

    task automatic test_stability();
        n_checks++;
        if (stab_viol != 0) begin
            n_errors++; $display("FAIL cmd_hold_stable: got %0d violations, expected 0", stab_viol);
        end
        n_checks++;
        if (cmd_quad !== 1'b0) begin
            n_errors++; $display("FAIL cmd_quad: got %b, expected 0", cmd_quad);
        end
    endtask

    initial begin
        test_reset();
        test_erase();
        test_program_full();
        test_read_status();
        test_poll_timeout();
        test_bad_ops();
        test_random();
        test_reset_mid();
        test_read_status();
        test_stability();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 90000 cycles, expected to finish earlier");
        $fatal(1);
    end

endmodule
